// File: rtl/vic_pkg.sv
// Shared VIC constants and arbiter state encoding, common to the register block and the arbiter.
package vic_pkg;
    localparam int NUM_IRQ    = 31;
    localparam int PRIO_WIDTH = 4;
    localparam int VEC_WIDTH  = 5;
    localparam int NEST_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_SERVICE = 2'd2
    } vic_state_e;
endpackage

// File: rtl/vic_prio_select.sv
// Combinational winner search: highest priority among eligible sources, lowest index on a tie.
module vic_prio_select
    import vic_pkg::*;
(
    input  logic [NUM_IRQ-1:0]            elig,
    input  logic [NUM_IRQ*PRIO_WIDTH-1:0] prio_bus,
    output logic                          vld,
    output logic [VEC_WIDTH-1:0]          vec,
    output logic [PRIO_WIDTH-1:0]         prio
);
    logic [PRIO_WIDTH-1:0] cand_s;
    logic                  take_s;

    // Strict greater-than keeps the earlier (lower) index when priorities tie.
    always_comb begin
        prio   = {PRIO_WIDTH{1'b0}};
        vec    = {VEC_WIDTH{1'b0}};
        cand_s = {PRIO_WIDTH{1'b0}};
        take_s = 1'b0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            cand_s = elig[n] ? prio_bus[n*PRIO_WIDTH +: PRIO_WIDTH] : {PRIO_WIDTH{1'b0}};
            take_s = (cand_s > prio);
            prio   = take_s ? cand_s : prio;
            vec    = take_s ? VEC_WIDTH'(n) : vec;
        end
        vld = (prio != {PRIO_WIDTH{1'b0}});
    end
endmodule

// File: rtl/vic_irq_arbiter.sv
// VIC interrupt arbiter: request/ack handshake to the CPU and in-service tracking until EOI.
// Define VIC_NESTING_EN for priority preemption with a NEST_DEPTH-entry in-service stack.
module vic_irq_arbiter
    import vic_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IRQ-1:0]            i_irq,
    input  logic [NUM_IRQ*PRIO_WIDTH-1:0] i_prio,
    input  logic                          i_enable,
    output logic                          o_irq_req,
    output logic [VEC_WIDTH-1:0]          o_irq_vector,
    input  logic                          i_irq_ack,
    input  logic                          i_eoi,
    output logic                          o_in_service,
    output logic [VEC_WIDTH-1:0]          o_active_vector,
    output logic [2:0]                    o_nest_level
);
`ifdef VIC_NESTING_EN
    localparam int STK_DEPTH = NEST_DEPTH;
`else
    localparam int STK_DEPTH = 1;
`endif

    logic [NUM_IRQ-1:0]    irq_r, raw_s, insvc_s, elig_s;
    logic                  sel_vld_s, win_vld_r, pend_elig_s;
    logic [VEC_WIDTH-1:0]  sel_vec_s, win_vec_r, pend_vec_r, active_vec_r, act_vec_nxt_s;
    logic [PRIO_WIDTH-1:0] sel_prio_s, win_prio_r, pend_prio_r, top_prio_s;
    logic [VEC_WIDTH-1:0]  stk_vec_r  [STK_DEPTH];
    logic [PRIO_WIDTH-1:0] stk_prio_r [STK_DEPTH];
    logic [2:0]            nest_r, nest_nxt_s;
    logic                  push_s, pop_s, load_s, irq_req_r, in_service_r;
    vic_state_e            state_r, state_nxt_s;

    // Eligibility: raw qualifies line/priority/enable, in-service sources are then masked out.
    always_comb begin
        insvc_s    = {NUM_IRQ{1'b0}};
        raw_s      = {NUM_IRQ{1'b0}};
        top_prio_s = {PRIO_WIDTH{1'b0}};
        for (int i = 0; i < STK_DEPTH; i++) begin
            for (int n = 0; n < NUM_IRQ; n++) begin
                insvc_s[n] = insvc_s[n] | ((i < int'(nest_r)) && (stk_vec_r[i] == VEC_WIDTH'(n)));
            end
            top_prio_s = (int'(nest_r) == i + 1) ? stk_prio_r[i] : top_prio_s;
        end
        for (int n = 0; n < NUM_IRQ; n++) begin
            raw_s[n] = irq_r[n] & (i_prio[n*PRIO_WIDTH +: PRIO_WIDTH] != {PRIO_WIDTH{1'b0}}) & i_enable;
        end
        elig_s      = raw_s & ~insvc_s;
        pend_elig_s = raw_s[pend_vec_r];
    end

    vic_prio_select u_sel (
        .elig     (elig_s),
        .prio_bus (i_prio),
        .vld      (sel_vld_s),
        .vec      (sel_vec_s),
        .prio     (sel_prio_s)
    );

    // Input sampling and winner pipeline; the winner is discarded whenever the stack changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r      <= {NUM_IRQ{1'b0}};
            win_vld_r  <= 1'b0;
            win_vec_r  <= {VEC_WIDTH{1'b0}};
            win_prio_r <= {PRIO_WIDTH{1'b0}};
        end else begin
            irq_r      <= i_irq;
            win_vld_r  <= sel_vld_s & ~(push_s | pop_s);
            win_vec_r  <= sel_vec_s;
            win_prio_r <= sel_prio_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state; ack outranks withdrawal, and a full stack blocks preemption.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_vld_r) state_nxt_s = ST_PEND;
                else           state_nxt_s = ST_IDLE;
            end
            ST_PEND: begin
                if (i_irq_ack)         state_nxt_s = ST_SERVICE;
                else if (!pend_elig_s) state_nxt_s = (nest_r != 3'd0) ? ST_SERVICE : ST_IDLE;
                else                   state_nxt_s = ST_PEND;
            end
            ST_SERVICE: begin
                if (i_eoi && (nest_r != 3'd0))
                    state_nxt_s = (nest_r == 3'd1) ? ST_IDLE : ST_SERVICE;
                else if (win_vld_r && (win_prio_r > top_prio_s) && (nest_r < 3'(STK_DEPTH)))
                    state_nxt_s = ST_PEND;
                else
                    state_nxt_s = ST_SERVICE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/datapath decode: stack push/pop, vector latch and next top-of-stack vector.
    always_comb begin
        push_s        = (state_r == ST_PEND) & i_irq_ack;
        pop_s         = (state_r == ST_SERVICE) & i_eoi & (nest_r != 3'd0);
        load_s        = (state_r != ST_PEND) & (state_nxt_s == ST_PEND);
        nest_nxt_s    = nest_r + {2'b00, push_s} - {2'b00, pop_s};
        act_vec_nxt_s = active_vec_r;
        if (push_s) begin
            act_vec_nxt_s = pend_vec_r;
        end else if (pop_s) begin
            act_vec_nxt_s = {VEC_WIDTH{1'b0}};
            for (int i = 0; i < STK_DEPTH; i++) begin
                act_vec_nxt_s = (int'(nest_r) == i + 2) ? stk_vec_r[i] : act_vec_nxt_s;
            end
        end else begin
            act_vec_nxt_s = active_vec_r;
        end
    end

    // Registered outputs and in-service stack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_req_r    <= 1'b0;
            pend_vec_r   <= {VEC_WIDTH{1'b0}};
            pend_prio_r  <= {PRIO_WIDTH{1'b0}};
            nest_r       <= 3'd0;
            in_service_r <= 1'b0;
            active_vec_r <= {VEC_WIDTH{1'b0}};
            for (int i = 0; i < STK_DEPTH; i++) begin
                stk_vec_r[i]  <= {VEC_WIDTH{1'b0}};
                stk_prio_r[i] <= {PRIO_WIDTH{1'b0}};
            end
        end else begin
            irq_req_r    <= (state_nxt_s == ST_PEND);
            nest_r       <= nest_nxt_s;
            in_service_r <= (nest_nxt_s != 3'd0);
            active_vec_r <= act_vec_nxt_s;
            if (load_s) begin
                pend_vec_r  <= win_vec_r;
                pend_prio_r <= win_prio_r;
            end
            for (int i = 0; i < STK_DEPTH; i++) begin
                if (push_s && (int'(nest_r) == i)) begin
                    stk_vec_r[i]  <= pend_vec_r;
                    stk_prio_r[i] <= pend_prio_r;
                end
            end
        end
    end

    assign o_irq_req       = irq_req_r;
    assign o_irq_vector    = pend_vec_r;
    assign o_in_service    = in_service_r;
    assign o_active_vector = active_vec_r;
    assign o_nest_level    = nest_r;
endmodule

// File: tb/tb_vic_irq_arbiter.sv
// Self-checking bench for vic_irq_arbiter; the reference model picks winners from a priority table and tracks service in a queue.
module tb_vic_irq_arbiter;
    import vic_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_IRQ-1:0]            irq;
    logic [NUM_IRQ*PRIO_WIDTH-1:0] prio_bus;
    logic                          enable, ack, eoi;
    logic                          irq_req, in_service;
    logic [VEC_WIDTH-1:0]          irq_vector, active_vector;
    logic [2:0]                    nest_level;

    int tests_run    = 0;
    int tests_failed = 0;
    int prio_tab [NUM_IRQ];
    int svc_q [$];

    vic_irq_arbiter dut (
        .clk(clk), .rst(rst), .i_irq(irq), .i_prio(prio_bus), .i_enable(enable),
        .o_irq_req(irq_req), .o_irq_vector(irq_vector), .i_irq_ack(ack), .i_eoi(eoi),
        .o_in_service(in_service), .o_active_vector(active_vector), .o_nest_level(nest_level)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_prio();
        for (int n = 0; n < NUM_IRQ; n++) prio_bus[n*PRIO_WIDTH +: PRIO_WIDTH] = PRIO_WIDTH'(prio_tab[n]);
    endtask

    // Reference rule: highest nonzero priority among raised, enabled, not-in-service lines; lowest index on tie.
    function automatic int model_winner();
        int best = -1;
        int bp   = 0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            bit busy = 1'b0;
            foreach (svc_q[k]) if (svc_q[k] == n) busy = 1'b1;
            if (irq[n] && enable && !busy && prio_tab[n] > bp) begin
                bp   = prio_tab[n];
                best = n;
            end
        end
        return best;
    endfunction

    task automatic wait_req(input int max_edges, output int edges, output bit got);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < max_edges) begin
            tick();
            edges++;
            got = (irq_req === 1'b1);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic clear_all();
        irq = {NUM_IRQ{1'b0}};
        while (svc_q.size() > 0) begin
            do_eoi();
            void'(svc_q.pop_back());
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        tests_run++; if (irq_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %0b want 0", irq_req); end
        tests_run++; if (irq_vector !== 5'd0) begin tests_failed++; $display("FAIL reset_vec: got %0d want 0", irq_vector); end
        tests_run++; if (in_service !== 1'b0) begin tests_failed++; $display("FAIL reset_insvc: got %0b want 0", in_service); end
        tests_run++; if (active_vector !== 5'd0) begin tests_failed++; $display("FAIL reset_active: got %0d want 0", active_vector); end
        tests_run++; if (nest_level !== 3'd0) begin tests_failed++; $display("FAIL reset_nest: got %0d want 0", nest_level); end
    endtask

    task automatic test_latency();
        prio_tab[7] = 5; apply_prio();
        irq[7] = 1'b1;
        tick();
        tests_run++; if (irq_req !== 1'b0) begin tests_failed++; $display("FAIL lat_k: got %0b want 0", irq_req); end
        tick();
        tests_run++; if (irq_req !== 1'b0) begin tests_failed++; $display("FAIL lat_k1: got %0b want 0", irq_req); end
        tick();
        tests_run++; if (irq_req !== 1'b1 || irq_vector !== 5'(model_winner())) begin
            tests_failed++; $display("FAIL lat_k2: got req=%0b vec=%0d want req=1 vec=7", irq_req, irq_vector); end
        do_ack(); svc_q.push_back(7);
        tests_run++; if (irq_req !== 1'b0 || in_service !== 1'b1 || active_vector !== 5'd7 || nest_level !== 3'd1) begin
            tests_failed++; $display("FAIL lat_ack: got req=%0b insvc=%0b act=%0d nest=%0d want 0 1 7 1", irq_req, in_service, active_vector, nest_level); end
        irq[7] = 1'b0;
        do_eoi(); void'(svc_q.pop_back());
        tests_run++; if (in_service !== 1'b0 || nest_level !== 3'd0) begin
            tests_failed++; $display("FAIL lat_eoi: got insvc=%0b nest=%0d want 0 0", in_service, nest_level); end
        prio_tab[7] = 0; apply_prio();
        clear_all();
    endtask

    task automatic test_priority();
        int e; bit g; int exp_v;
        prio_tab[3] = 9; prio_tab[20] = 9; apply_prio();
        irq[3] = 1'b1; irq[20] = 1'b1; exp_v = model_winner();
        wait_req(6, e, g);
        tests_run++; if (!g || irq_vector !== 5'(exp_v)) begin tests_failed++; $display("FAIL tie_vec: got req=%0b vec=%0d want vec=%0d", g, irq_vector, exp_v); end
        do_ack(); svc_q.push_back(exp_v);
        clear_all();
        prio_tab[20] = 12; apply_prio();
        irq[3] = 1'b1; irq[20] = 1'b1; exp_v = model_winner();
        wait_req(6, e, g);
        tests_run++; if (!g || irq_vector !== 5'(exp_v)) begin tests_failed++; $display("FAIL hi_vec: got req=%0b vec=%0d want vec=%0d", g, irq_vector, exp_v); end
        do_ack(); svc_q.push_back(exp_v);
        clear_all();
        prio_tab[3] = 0; prio_tab[20] = 0; prio_tab[11] = 0; apply_prio();
        irq[11] = 1'b1;
        wait_req(8, e, g);
        tests_run++; if (g) begin tests_failed++; $display("FAIL prio0: got req=1 vec=%0d want no request", irq_vector); end
        clear_all();
    endtask

    task automatic test_withdraw();
        int e; bit g;
        prio_tab[4] = 6; apply_prio();
        irq[4] = 1'b1;
        wait_req(6, e, g);
        tests_run++; if (!g || irq_vector !== 5'd4) begin tests_failed++; $display("FAIL wd_req: got req=%0b vec=%0d want 1 4", g, irq_vector); end
        irq[4] = 1'b0;
        tick(); tick();
        tests_run++; if (irq_req !== 1'b0 || in_service !== 1'b0) begin tests_failed++; $display("FAIL wd_drop: got req=%0b insvc=%0b want 0 0", irq_req, in_service); end
        wait_req(4, e, g);
        tests_run++; if (g) begin tests_failed++; $display("FAIL wd_idle: got req=1 want 0"); end
        irq[4] = 1'b1;
        wait_req(6, e, g);
        ack = 1'b1; irq[4] = 1'b0; tick(); ack = 1'b0;
        svc_q.push_back(4);
        tests_run++; if (!g || irq_req !== 1'b0 || in_service !== 1'b1 || active_vector !== 5'd4) begin
            tests_failed++; $display("FAIL wd_ackdrop: got req=%0b insvc=%0b act=%0d want 0 1 4", irq_req, in_service, active_vector); end
        clear_all();
        irq[4] = 1'b1;
        wait_req(6, e, g);
        do_ack(); svc_q.push_back(4);
        enable = 1'b0;
        repeat (3) tick();
        tests_run++; if (!g || in_service !== 1'b1 || active_vector !== 5'd4) begin
            tests_failed++; $display("FAIL en_hold: got insvc=%0b act=%0d want 1 4", in_service, active_vector); end
        enable = 1'b1;
        clear_all();
        irq[4] = 1'b1;
        wait_req(6, e, g);
        enable = 1'b0;
        tick(); tick();
        tests_run++; if (!g || irq_req !== 1'b0 || in_service !== 1'b0) begin
            tests_failed++; $display("FAIL en_wd: got req=%0b insvc=%0b want 0 0", irq_req, in_service); end
        irq[4] = 1'b0; tick(); tick(); enable = 1'b1;
        prio_tab[4] = 0; apply_prio();
        clear_all();
    endtask

    task automatic test_nesting();
        int e; bit g;
        prio_tab[2] = 3; prio_tab[9] = 10; apply_prio();
        irq[2] = 1'b1;
        wait_req(6, e, g);
        tests_run++; if (!g || irq_vector !== 5'd2) begin tests_failed++; $display("FAIL nest_v2: got req=%0b vec=%0d want 1 2", g, irq_vector); end
        do_ack(); svc_q.push_back(2);
        irq[9] = 1'b1;
`ifdef VIC_NESTING_EN
        wait_req(6, e, g);
        tests_run++; if (!g || irq_vector !== 5'd9) begin tests_failed++; $display("FAIL nest_v9: got req=%0b vec=%0d want 1 9", g, irq_vector); end
        do_ack(); svc_q.push_back(9);
        tests_run++; if (nest_level !== 3'(svc_q.size()) || active_vector !== 5'd9) begin
            tests_failed++; $display("FAIL nest_lvl2: got nest=%0d act=%0d want 2 9", nest_level, active_vector); end
        irq[9] = 1'b0;
        do_eoi(); void'(svc_q.pop_back());
        tests_run++; if (active_vector !== 5'(svc_q[$]) || nest_level !== 3'd1 || in_service !== 1'b1) begin
            tests_failed++; $display("FAIL nest_eoi1: got act=%0d nest=%0d want 2 1", active_vector, nest_level); end
        irq[2] = 1'b0;
        do_eoi(); void'(svc_q.pop_back());
        tests_run++; if (in_service !== 1'b0 || nest_level !== 3'd0) begin
            tests_failed++; $display("FAIL nest_eoi2: got insvc=%0b nest=%0d want 0 0", in_service, nest_level); end
`else
        wait_req(8, e, g);
        tests_run++; if (g) begin tests_failed++; $display("FAIL nopre_req: got req=1 vec=%0d want 0", irq_vector); end
        irq[2] = 1'b0;
        do_eoi(); void'(svc_q.pop_back());
        tests_run++; if (irq_req !== 1'b0 || in_service !== 1'b0) begin tests_failed++; $display("FAIL nopre_e0: got req=%0b insvc=%0b want 0 0", irq_req, in_service); end
        tick();
        tests_run++; if (irq_req !== 1'b0) begin tests_failed++; $display("FAIL nopre_e1: got %0b want 0", irq_req); end
        tick();
        tests_run++; if (irq_req !== 1'b1 || irq_vector !== 5'd9) begin
            tests_failed++; $display("FAIL nopre_e2: got req=%0b vec=%0d want 1 9", irq_req, irq_vector); end
        do_ack(); svc_q.push_back(9);
        tests_run++; if (nest_level !== 3'd1 || active_vector !== 5'd9) begin
            tests_failed++; $display("FAIL nopre_lvl: got nest=%0d act=%0d want 1 9", nest_level, active_vector); end
`endif
        prio_tab[2] = 0; prio_tab[9] = 0; apply_prio();
        clear_all();
    endtask

    task automatic test_reset_mid();
        int e; bit g;
        prio_tab[5] = 7; apply_prio();
        irq[5] = 1'b1;
        wait_req(6, e, g);
        #2 rst = 1'b0;
        #1;
        svc_q.delete();
        tests_run++; if (!g || irq_req !== 1'b0 || irq_vector !== 5'd0 || in_service !== 1'b0 || active_vector !== 5'd0 || nest_level !== 3'd0) begin
            tests_failed++; $display("FAIL rst_async: got req=%0b vec=%0d insvc=%0b act=%0d nest=%0d want all 0", irq_req, irq_vector, in_service, active_vector, nest_level); end
        tick(); tick();
        rst = 1'b1;
        wait_req(6, e, g);
        tests_run++; if (!g || irq_vector !== 5'd5 || e < 2 || e > 3) begin
            tests_failed++; $display("FAIL rst_rereq: got req=%0b vec=%0d edges=%0d want 1 5 edges 2..3", g, irq_vector, e); end
        do_ack(); svc_q.push_back(5);
        prio_tab[5] = 0; apply_prio();
        clear_all();
    endtask

    task automatic test_random();
        int e; bit g; int exp_v;
        for (int it = 0; it < 40; it++) begin
            for (int n = 0; n < NUM_IRQ; n++) prio_tab[n] = int'($urandom_range(15, 0));
            apply_prio();
            irq = NUM_IRQ'($urandom & $urandom);
            exp_v = model_winner();
            wait_req(5, e, g);
            if (exp_v < 0) begin
                tests_run++; if (g) begin tests_failed++; $display("FAIL rnd_none: it=%0d got vec=%0d want no request", it, irq_vector); end
            end else begin
                tests_run++; if (!g || irq_vector !== 5'(exp_v)) begin
                    tests_failed++; $display("FAIL rnd_vec: it=%0d got req=%0b vec=%0d want %0d", it, g, irq_vector, exp_v); end
                do_ack(); svc_q.push_back(exp_v);
                tests_run++; if (active_vector !== 5'(svc_q[$]) || nest_level !== 3'(svc_q.size())) begin
                    tests_failed++; $display("FAIL rnd_svc: it=%0d got act=%0d nest=%0d want %0d %0d", it, active_vector, nest_level, svc_q[$], svc_q.size()); end
            end
            clear_all();
            tests_run++; if (in_service !== 1'b0) begin tests_failed++; $display("FAIL rnd_clr: it=%0d got insvc=1 want 0", it); end
        end
    endtask

    initial begin
        rst = 1'b0; irq = {NUM_IRQ{1'b0}}; enable = 1'b1; ack = 1'b0; eoi = 1'b0;
        for (int n = 0; n < NUM_IRQ; n++) prio_tab[n] = 0;
        apply_prio();
        tick(); tick();
        test_reset();
        rst = 1'b1;
        repeat (3) tick();
        test_latency();
        test_priority();
        test_withdraw();
        test_nesting();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
